// File: rtl/seq_pattern_gen_if.sv
// Purpose: control/config inputs and serial-line outputs of the bit-pattern transmitter.
// Latency: none. This file only groups the signals.
// Backpressure: none. The serial line has no ready; start is accepted only while busy==0.
//
// Signals (direction as seen by the transmitter, which uses the slave modport):
//   start, abort            in   job request / synchronous cancel
//   pattern, len, rep, gap  in   job configuration, sampled when start is accepted
//   idle_bit                in   line level while x_valid==0
//   x, x_valid              out  serial data and its qualifier
//   busy, done, err         out  job status
interface seq_pattern_gen_if #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int CNT_W   = 8,
    parameter int GAP_W   = 4
);
    logic               start;
    logic               abort;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic [CNT_W-1:0]   rep;
    logic [GAP_W-1:0]   gap;
    logic               idle_bit;
    logic               x;
    logic               x_valid;
    logic               busy;
    logic               done;
    logic               err;

    // The traffic controller that requests jobs and watches the line.
    modport master (
        output start, abort, pattern, len, rep, gap, idle_bit,
        input  x, x_valid, busy, done, err
    );

    // The transmitter itself.
    modport slave (
        input  start, abort, pattern, len, rep, gap, idle_bit,
        output x, x_valid, busy, done, err
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// Purpose: serial bit-pattern transmitter. Sends a latched pattern MSB-first, rep times, with gap idle cycles between repetitions.
// Latency: the first bit is on x one cycle after start is accepted. done pulses one cycle after the last bit.
// Backpressure: none downstream. start is ignored while busy. abort cancels the job on the next edge.
//
// Ports:
//   clk    in  clock; all logic changes on posedge
//   reset  in  asynchronous, active-high; clears the state and drives every output to 0
//   sp     slave modport of seq_pattern_gen_if
//            inputs  : start, abort, pattern, len, rep, gap, idle_bit
//            outputs : x, x_valid, busy, done, err (all registered)
module seq_pattern_gen #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int CNT_W   = 8,
    parameter int GAP_W   = 4
) (
    input  logic            clk,
    input  logic            reset,
    seq_pattern_gen_if.slave sp
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;

    // Latched copy of the job configuration. Live inputs are ignored while busy.
    logic [MAX_LEN-1:0] r_pat,   w_pat_nxt;
    logic [LEN_W-1:0]   r_len,   w_len_nxt;
    logic [GAP_W-1:0]   r_gap,   w_gap_nxt;

    // r_idx    : index of the bit currently on x
    // r_rep    : repetitions remaining, counting the one in progress
    // r_gcnt   : gap cycles remaining, counting the one currently on the line
    logic [LEN_W-1:0]   r_idx,   w_idx_nxt;
    logic [CNT_W-1:0]   r_rep,   w_rep_nxt;
    logic [GAP_W-1:0]   r_gcnt,  w_gcnt_nxt;

    // Registered outputs.
    logic               r_x,       w_x_nxt;
    logic               r_x_valid, w_x_valid_nxt;
    logic               r_busy,    w_busy_nxt;
    logic               r_done,    w_done_nxt;
    logic               r_err,     w_err_nxt;

    logic               w_cfg_legal;
    logic               w_first_live;
    logic               w_first_lat;
    logic               w_next_bit;

    // Bit select with a runtime index, written as a mask so the index width
    // does not have to match the vector's natural index width.
    function automatic logic f_bit_at(input logic [MAX_LEN-1:0] vec,
                                      input logic [LEN_W-1:0]   idx);
        return |(vec & (MAX_LEN'(1) << idx));
    endfunction

    assign w_cfg_legal  = (sp.len != '0) && (sp.len <= LEN_W'(MAX_LEN)) && (sp.rep != '0);

    // First bit of a job just being accepted. It comes from the live inputs
    // because the latched copy is only written at this same edge.
    assign w_first_live = f_bit_at(sp.pattern, sp.len - LEN_W'(1));

    // First bit of a follow-on repetition, taken from the latched copy.
    assign w_first_lat  = f_bit_at(r_pat, r_len - LEN_W'(1));

    // Bit that follows the one now on the line within the same repetition.
    assign w_next_bit   = f_bit_at(r_pat, r_idx - LEN_W'(1));

    // Next-state and next-output logic. Each register computes the value it
    // will show during the following cycle. This keeps every output registered
    // while start still produces its first bit one cycle after acceptance.
    always_comb begin
        w_state_nxt   = r_state;
        w_pat_nxt     = r_pat;
        w_len_nxt     = r_len;
        w_gap_nxt     = r_gap;
        w_idx_nxt     = r_idx;
        w_rep_nxt     = r_rep;
        w_gcnt_nxt    = r_gcnt;
        w_x_nxt       = sp.idle_bit;
        w_x_valid_nxt = 1'b0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                // abort in IDLE only suppresses a start in the same cycle.
                if (sp.start && !sp.abort) begin
                    if (w_cfg_legal) begin
                        w_pat_nxt     = sp.pattern;
                        w_len_nxt     = sp.len;
                        w_gap_nxt     = sp.gap;
                        w_idx_nxt     = sp.len - LEN_W'(1);
                        w_rep_nxt     = sp.rep;
                        w_gcnt_nxt    = '0;
                        w_state_nxt   = S_SEND;
                        w_x_nxt       = w_first_live;
                        w_x_valid_nxt = 1'b1;
                        w_busy_nxt    = 1'b1;
                    end else begin
                        w_err_nxt     = 1'b1;
                    end
                end
            end

            S_SEND: begin
                if (sp.abort) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                    w_rep_nxt   = '0;
                    w_gcnt_nxt  = '0;
                end else if (r_idx != '0) begin
                    // Still inside this repetition.
                    w_idx_nxt     = r_idx - LEN_W'(1);
                    w_x_nxt       = w_next_bit;
                    w_x_valid_nxt = 1'b1;
                    w_busy_nxt    = 1'b1;
                end else if (r_rep > CNT_W'(1)) begin
                    // Bit 0 of a repetition that is not the last one.
                    w_rep_nxt  = r_rep - CNT_W'(1);
                    w_busy_nxt = 1'b1;
                    if (r_gap != '0) begin
                        w_state_nxt = S_GAP;
                        w_gcnt_nxt  = r_gap;
                    end else begin
                        w_idx_nxt     = r_len - LEN_W'(1);
                        w_x_nxt       = w_first_lat;
                        w_x_valid_nxt = 1'b1;
                    end
                end else begin
                    // Bit 0 of the last repetition. No gap follows it.
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_idx_nxt   = '0;
                    w_rep_nxt   = '0;
                end
            end

            S_GAP: begin
                if (sp.abort) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                    w_rep_nxt   = '0;
                    w_gcnt_nxt  = '0;
                end else if (r_gcnt > GAP_W'(1)) begin
                    w_gcnt_nxt = r_gcnt - GAP_W'(1);
                    w_busy_nxt = 1'b1;
                end else begin
                    // Last gap cycle is on the line now. Restart the pattern.
                    w_state_nxt   = S_SEND;
                    w_gcnt_nxt    = '0;
                    w_idx_nxt     = r_len - LEN_W'(1);
                    w_x_nxt       = w_first_lat;
                    w_x_valid_nxt = 1'b1;
                    w_busy_nxt    = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pat     <= '0;
            r_len     <= '0;
            r_gap     <= '0;
            r_idx     <= '0;
            r_rep     <= '0;
            r_gcnt    <= '0;
            r_x       <= 1'b0;
            r_x_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pat     <= w_pat_nxt;
            r_len     <= w_len_nxt;
            r_gap     <= w_gap_nxt;
            r_idx     <= w_idx_nxt;
            r_rep     <= w_rep_nxt;
            r_gcnt    <= w_gcnt_nxt;
            r_x       <= w_x_nxt;
            r_x_valid <= w_x_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign sp.x       = r_x;
    assign sp.x_valid = r_x_valid;
    assign sp.busy    = r_busy;
    assign sp.done    = r_done;
    assign sp.err     = r_err;

endmodule

// File: tb/tb_seq_pattern_gen.sv
module tb_seq_pattern_gen;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int CNT_W   = 8;
    localparam int GAP_W   = 4;

    logic clk = 1'b0;
    logic reset;

    seq_pattern_gen_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) sp_if ();

    seq_pattern_gen #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .sp    (sp_if)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // DUT outputs packed as {x, x_valid, busy, done, err}.
    logic [4:0] outs;
    assign outs = {sp_if.x, sp_if.x_valid, sp_if.busy, sp_if.done, sp_if.err};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model. When a job is accepted, the model expands the whole
    // expected line activity into a list of per-cycle entries. Each entry is
    // {use_idle_bit, x, x_valid, busy, done, err}. After that the model pops
    // one entry per clock until the list is empty or the job is aborted.
    // ------------------------------------------------------------------
    logic [5:0] job_q[$];
    logic [4:0] m_out = '0;

    function automatic logic cfg_legal(input int l, input int r);
        return (l >= 1) && (l <= MAX_LEN) && (r >= 1);
    endfunction

    function automatic void build_job();
        int l;
        int r;
        int g;
        l = int'(sp_if.len);
        r = int'(sp_if.rep);
        g = int'(sp_if.gap);
        job_q.delete();
        for (int k = 0; k < r; k++) begin
            for (int b = l - 1; b >= 0; b--)
                job_q.push_back({1'b0, sp_if.pattern[b], 4'b1100});
            if (k < r - 1)
                for (int j = 0; j < g; j++)
                    job_q.push_back({1'b1, 1'b0, 4'b0100});
        end
        job_q.push_back({1'b1, 1'b0, 4'b0010});
    endfunction

    function automatic logic [4:0] resolve(input logic [5:0] e);
        return {(e[5] ? sp_if.idle_bit : e[4]), e[3:0]};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            job_q.delete();
            m_out <= '0;
        end else if (m_out[2]) begin
            if (sp_if.abort) begin
                job_q.delete();
                m_out <= {sp_if.idle_bit, 4'b0000};
            end else if (job_q.size() > 0) begin
                m_out <= resolve(job_q.pop_front());
            end else begin
                m_out <= {sp_if.idle_bit, 4'b0000};
            end
        end else if (sp_if.start && !sp_if.abort) begin
            if (cfg_legal(int'(sp_if.len), int'(sp_if.rep))) begin
                build_job();
                m_out <= resolve(job_q.pop_front());
            end else begin
                m_out <= {sp_if.idle_bit, 4'b0001};
            end
        end else begin
            m_out <= {sp_if.idle_bit, 4'b0000};
        end
    end

    // Per-cycle comparison of the DUT against the model, away from posedge.
    always @(negedge clk) begin
        check("cycle_vs_model", {27'd0, outs}, {27'd0, m_out});
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Inputs change 1 time unit after posedge.
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [15:0] p, input int l, input int r, input int g);
        sp_if.pattern = p;
        sp_if.len     = LEN_W'(l);
        sp_if.rep     = CNT_W'(r);
        sp_if.gap     = GAP_W'(g);
    endtask

    // Sample n consecutive cycles. The oldest sample ends up as the MSB of each vector.
    task automatic capture(input int n, output logic [31:0] vx, output logic [31:0] vv,
                           output logic [31:0] vb, output logic [31:0] vd);
        vx = '0; vv = '0; vb = '0; vd = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vx = {vx[30:0], sp_if.x};
            vv = {vv[30:0], sp_if.x_valid};
            vb = {vb[30:0], sp_if.busy};
            vd = {vd[30:0], sp_if.done};
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!sp_if.busy) break;
        end
        check(name, {31'd0, (k < 200)}, 32'd1);
        cyc();
    endtask

    logic [31:0] vx, vv, vb, vd;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        sp_if.start    = 1'b0;
        sp_if.abort    = 1'b0;
        sp_if.idle_bit = 1'b0;
        set_cfg(16'h0000, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {27'd0, outs}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc();

        // 1: single repetition of 1011.
        set_cfg(16'h000B, 4, 1, 0);
        sp_if.start = 1'b1;
        cyc();
        sp_if.start = 1'b0;
        capture(5, vx, vv, vb, vd);
        check("t1_x",    vx, 32'b10110);
        check("t1_vld",  vv, 32'b11110);
        check("t1_busy", vb, 32'b11110);
        check("t1_done", vd, 32'b00001);
        cyc();

        // 2: three repetitions with a 2-cycle gap, idle level 0.
        sp_if.idle_bit = 1'b0;
        set_cfg(16'h000B, 4, 3, 2);
        sp_if.start = 1'b1;
        cyc();
        sp_if.start = 1'b0;
        capture(17, vx, vv, vb, vd);
        check("t2_x",    vx, 32'b10110010110010110);
        check("t2_vld",  vv, 32'b11110011110011110);
        check("t2_busy", vb, 32'b11111111111111110);
        check("t2_done", vd, 32'b00000000000000001);
        wait_idle("t2_idle_timeout");

        // 3: illegal configurations raise err for exactly one cycle.
        for (int c = 0; c < 3; c++) begin
            case (c)
                0:       set_cfg(16'h000B, 0, 1, 0);
                1:       set_cfg(16'h000B, 4, 0, 0);
                default: set_cfg(16'h000B, 17, 1, 0);
            endcase
            sp_if.start = 1'b1;
            cyc();
            sp_if.start = 1'b0;
            @(negedge clk);
            check("t3_err_pulse", {27'd0, outs}, 32'b00001);
            cyc();
            @(negedge clk);
            check("t3_err_clear", {27'd0, outs}, 32'b00000);
            cyc();
        end
        // abort in IDLE drops start, whether the config is illegal or legal.
        set_cfg(16'h000B, 0, 1, 0);
        sp_if.start = 1'b1; sp_if.abort = 1'b1;
        cyc();
        sp_if.start = 1'b0; sp_if.abort = 1'b0;
        @(negedge clk);
        check("t3_abort_drops_err", {31'd0, sp_if.err}, 32'd0);
        cyc();
        set_cfg(16'h000B, 4, 1, 0);
        sp_if.start = 1'b1; sp_if.abort = 1'b1;
        cyc();
        sp_if.start = 1'b0; sp_if.abort = 1'b0;
        @(negedge clk);
        check("t3_abort_drops_start", {31'd0, sp_if.busy}, 32'd0);
        cyc();

        // 4: abort mid-job, then a fresh start.
        set_cfg(16'h000B, 4, 2, 0);
        sp_if.start = 1'b1;
        cyc();                  // T+1
        sp_if.start = 1'b0;
        cyc();                  // T+2
        sp_if.abort = 1'b1;
        cyc();                  // T+3
        sp_if.abort = 1'b0;
        @(negedge clk);
        check("t4_after_abort", {29'd0, sp_if.x_valid, sp_if.busy, sp_if.done}, 32'd0);
        cyc();                  // T+4
        set_cfg(16'h000A, 4, 1, 0);
        sp_if.start = 1'b1;
        cyc();                  // T+5
        sp_if.start = 1'b0;
        @(negedge clk);
        check("t4_restart_first_bit", {30'd0, sp_if.x, sp_if.x_valid}, 32'b11);
        wait_idle("t4_idle_timeout");

        // 5: asynchronous reset during a gap cycle.
        sp_if.idle_bit = 1'b1;
        set_cfg(16'h000B, 4, 2, 3);
        sp_if.start = 1'b1;
        cyc();                  // T+1
        sp_if.start = 1'b0;
        repeat (5) cyc();       // T+6, the second gap cycle
        @(negedge clk);
        check("t5_in_gap", {27'd0, outs}, 32'b10100);
        #1 reset = 1'b1;
        #1 check("t5_async_reset", {27'd0, outs}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cyc();
        @(negedge clk);
        check("t5_idle_after_reset", {27'd0, outs}, 32'b10000);
        capture(10, vx, vv, vb, vd);
        check("t5_no_done",  vd, 32'd0);
        check("t5_no_busy",  vb, 32'd0);
        check("t5_idle_lvl", vx, 32'b1111111111);
        cyc();

        // 6: start held high, so the restart is taken in the done cycle.
        sp_if.idle_bit = 1'b0;
        set_cfg(16'h000B, 4, 1, 0);
        sp_if.start = 1'b1;
        cyc();                  // T+1
        capture(10, vx, vv, vb, vd);
        check("t6_vld",  vv, 32'b1111011110);
        check("t6_done", vd, 32'b0000100001);
        check("t6_x",    vx, 32'b1011010110);
        cyc();
        sp_if.start = 1'b0;
        wait_idle("t6_idle_timeout");

        repeat (3) cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
